// File: rtl/fexp_iter.sv
// rtl/fexp_iter.sv - iterative fp32 e^x: range reduction, Horner polynomial, exponent rescale
// One shared fp32 multiplier and one shared fp32 adder are time-multiplexed across the FSM states.
module fexp_iter #(
  parameter int BIT_W        = 32,
  parameter int N_TERMS      = 8,
  parameter int RANGE_REDUCE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIT_W-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT_W-1:0] result
);

  if (BIT_W != 32) begin : g_bad_bit_w
    $error("fexp_iter: only BIT_W=32 (binary32) is supported");
  end
  if (N_TERMS < 1 || N_TERMS > 12) begin : g_bad_n_terms
    $error("fexp_iter: N_TERMS must be in 1..12");
  end

  localparam int          CW    = $clog2(N_TERMS + 1);
  localparam logic [31:0] LOG2E = 32'h3FB8AA3B;
  localparam logic [31:0] LN2   = 32'h3F317218;

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_RSUB, S_POLY, S_SCALE, S_DONE} state_t;

  // Round-to-nearest-even and pack; m carries the hidden bit in m[23]. Subnormals flush to zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [11:0] e,
                                          input logic [23:0] m, input logic g, input logic st);
    logic [24:0]        mr;
    logic signed [11:0] er;
    mr = {1'b0, m} + {24'd0, (g & (st | m[0]))};
    er = e;
    if (mr[24]) begin
      er = e + 12'sd1;
      mr = mr >> 1;
    end
    if (er >= 12'sd255)    fp_pack = {s, 8'hFF, 23'd0};
    else if (er <= 12'sd0) fp_pack = {s, 31'd0};
    else                   fp_pack = {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        prod;
    logic signed [11:0] e;
    logic               s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      fp_mul = {s, 31'd0};
    end else begin
      prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e    = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
      if (prod[47]) fp_mul = fp_pack(s, e + 12'sd1, prod[47:24], prod[23], |prod[22:0]);
      else          fp_mul = fp_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
    end
  endfunction

  // Smaller operand aligned into a 64-bit field; anything shifted past it only sets a sticky LSB.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        big, sml;
    logic [7:0]         d8;
    logic [63:0]        mb, ms;
    logic [64:0]        sum, nrm;
    logic signed [11:0] e;
    int                 pos;
    if (b[30:23] == 8'd0) begin
      fp_add = (a[30:23] == 8'd0) ? 32'd0 : a;
    end else if (a[30:23] == 8'd0) begin
      fp_add = b;
    end else begin
      if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
      else                    begin big = b; sml = a; end
      d8 = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 40'd0};
      if (d8 > 8'd40) ms = 64'd1;
      else            ms = {1'b1, sml[22:0], 40'd0} >> d8;
      if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms};
      else                    sum = {1'b0, mb} - {1'b0, ms};
      if (sum == 65'd0) begin
        fp_add = 32'd0;
      end else begin
        pos = 0;
        for (int i = 0; i < 65; i++) if (sum[i]) pos = i;
        nrm    = sum << (64 - pos);
        e      = $signed({4'd0, big[30:23]}) + 12'(pos - 63);
        fp_add = fp_pack(big[31], e, nrm[64:41], nrm[40], |nrm[39:0]);
      end
    end
  endfunction

  // Float to signed int, round half away from zero, magnitude clamped to 255.
  function automatic logic signed [8:0] f2k(input logic [31:0] t);
    logic [31:0] mag;
    logic [8:0]  m9;
    int          sh;
    mag = 32'd0;
    if (t[30:23] >= 8'd126) begin
      if (t[30:23] > 8'd134) begin
        mag = 32'd255;
      end else begin
        sh  = 150 - int'(t[30:23]);
        mag = ({8'd0, 1'b1, t[22:0]} + (32'd1 << (sh - 1))) >> sh;
        if (mag > 32'd255) mag = 32'd255;
      end
    end
    m9  = mag[8:0];
    f2k = t[31] ? -$signed(m9) : $signed(m9);
  endfunction

  function automatic logic [31:0] i2f(input logic signed [8:0] k);
    logic [8:0]  mag;
    logic [22:0] fr;
    int          pos;
    if (k == 9'sd0) begin
      i2f = 32'd0;
    end else begin
      mag = k[8] ? 9'(-k) : 9'(k);
      pos = 0;
      for (int i = 0; i < 9; i++) if (mag[i]) pos = i;
      fr  = {14'd0, mag} << (23 - pos);
      i2f = {k[8], 8'(127 + pos), fr};
    end
  endfunction

  // c_i = 1/i! rounded to fp32
  function automatic logic [31:0] coef(input logic [3:0] i);
    case (i)
      4'd0, 4'd1: coef = 32'h3F800000;
      4'd2:       coef = 32'h3F000000;
      4'd3:       coef = 32'h3E2AAAAB;
      4'd4:       coef = 32'h3D2AAAAB;
      4'd5:       coef = 32'h3C088889;
      4'd6:       coef = 32'h3AB60B61;
      4'd7:       coef = 32'h39500D01;
      4'd8:       coef = 32'h37D00D01;
      4'd9:       coef = 32'h3638EF1D;
      4'd10:      coef = 32'h3493F27E;
      4'd11:      coef = 32'h32D7322B;
      4'd12:      coef = 32'h310F76C7;
      default:    coef = 32'h00000000;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [31:0]           x_q, r_q, p_q, result_q;
  logic signed [8:0]     k_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           mul_a, mul_b, mul_y, add_a, add_b, add_y;
  logic                  is_special;
  logic [31:0]           special_val, scaled;
  logic signed [11:0]    exp_sum;

  assign mul_y  = fp_mul(mul_a, mul_b);
  assign add_y  = fp_add(add_a, add_b);
  assign result = result_q;

  // Special-case screen on the raw input bits; ordering matters (NaN first).
  always_comb begin
    is_special  = 1'b1;
    special_val = 32'h3F800000;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0)   special_val = 32'h7FC00000;
    else if (!x[31] && x[30:0] > 31'h42B17217)   special_val = 32'h7F800000;
    else if (x[31] && x[31:0] > 32'hC2AEAC50)    special_val = 32'h00000000;
    else if (x[30:23] == 8'd0)                   special_val = 32'h3F800000;
    else                                         is_special  = 1'b0;
  end

  always_comb begin
    exp_sum = $signed({4'd0, p_q[30:23]}) + 12'(k_q);
    if (p_q[30:23] == 8'd0 || exp_sum <= 12'sd0) scaled = 32'h00000000;
    else if (exp_sum >= 12'sd255)               scaled = 32'h7F800000;
    else                                        scaled = {1'b0, exp_sum[7:0], p_q[22:0]};
  end

  always_comb begin
    state_d   = state_q;
    mul_a     = 32'd0;
    mul_b     = 32'd0;
    add_a     = 32'd0;
    add_b     = 32'd0;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    case (state_q)
      S_IDLE:   if (in_valid) state_d = is_special ? S_DONE : S_REDUCE;
      S_REDUCE: begin
        mul_a   = x_q;
        mul_b   = LOG2E;
        state_d = S_RSUB;
      end
      S_RSUB: begin
        mul_a   = i2f(k_q);
        mul_b   = LN2;
        add_a   = x_q;
        add_b   = {~mul_y[31], mul_y[30:0]};
        state_d = S_POLY;
      end
      S_POLY: begin
        mul_a = p_q;
        mul_b = r_q;
        add_a = mul_y;
        add_b = coef(4'(cnt_q));
        if (cnt_q == '0) state_d = S_SCALE;
      end
      S_SCALE:  state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= 32'd0;
      r_q      <= 32'd0;
      p_q      <= 32'd0;
      k_q      <= 9'sd0;
      cnt_q    <= '0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          x_q <= x;
          if (is_special) result_q <= special_val;
        end
        S_REDUCE: k_q <= (RANGE_REDUCE != 0) ? f2k(mul_y) : 9'sd0;
        S_RSUB: begin
          r_q   <= add_y;
          p_q   <= coef(4'(N_TERMS));
          cnt_q <= CW'(N_TERMS - 1);
        end
        S_POLY: begin
          p_q <= add_y;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_SCALE: result_q <= scaled;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fexp_iter.sv
// tb/tb_fexp_iter.sv - scoreboard bench for fexp_iter against a real-arithmetic e^x model
module tb_fexp_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] x = 32'd0, result;

  logic        l_in_valid = 1'b0, l_out_ready = 1'b1;
  logic        l_in_ready, l_out_valid;
  logic [31:0] l_x = 32'd0, l_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          exact;
    logic [31:0] bits;
    real         val;
    int          tol;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  fexp_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  fexp_iter #(.N_TERMS(5), .RANGE_REDUCE(0)) dut_leg (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready), .x(l_x),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .result(l_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic real f2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(int'(b[30:23]) - 127));
    return b[31] ? -v : v;
  endfunction

  // Spec-level reference: specials by rule, otherwise e^x in double precision.
  function automatic exp_t model(input logic [31:0] xb, input int tol);
    exp_t m;
    m.exact = 1'b1; m.val = 0.0; m.tol = 0; m.lat = 1; m.acc = 0;
    if (xb[30:23] == 8'hFF && xb[22:0] != 23'd0)    m.bits = 32'h7FC00000;
    else if (!xb[31] && f2r(xb) > 88.7228391)       m.bits = 32'h7F800000;
    else if (xb[31] && f2r(xb) < -87.3365479)       m.bits = 32'h00000000;
    else if (xb[30:23] == 8'd0)                     m.bits = 32'h3F800000;
    else begin
      m.exact = 1'b0; m.bits = 32'd0; m.val = $exp(f2r(xb)); m.tol = tol; m.lat = 12;
    end
    if (xb[30:23] == 8'hFF && !xb[31] && xb[22:0] == 23'd0) m.bits = 32'h7F800000;
    if (xb[30:23] == 8'hFF &&  xb[31] && xb[22:0] == 23'd0) m.bits = 32'h00000000;
    return m;
  endfunction

  task automatic chk_bits(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic chk_close(input string name, input logic [31:0] act, input real want, input int tol);
    real ulp, err;
    int  e2;
    e2  = int'($floor($ln(want) / $ln(2.0)));
    ulp = 2.0 ** real'(e2 - 23);
    err = f2r(act) - want;
    if (err < 0.0) err = -err;
    total++;
    if (act[31] || err > real'(tol) * ulp) begin
      bad++;
      $display("FAIL %s: got %h (%g) want %g within %0d ulp", name, act, f2r(act), want, tol);
    end
  endtask

  // Monitor: every rising out_valid must match the oldest scoreboard entry.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want no output", result);
      end else begin
        e = sb.pop_front();
        if (e.exact) chk_bits("value", result, e.bits);
        else         chk_close("value", result, e.val, e.tol);
        chk_int("latency", cyc - e.acc + 1, e.lat);
      end
    end
    prev_v = out_valid;
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [31:0] xb, input int tol);
    exp_t m;
    bit   done;
    m = model(xb, tol);
    x = xb;
    in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (in_ready) begin
        m.acc = cyc + 1;
        sb.push_back(m);
        @(posedge clk);
        @(negedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!done) chk_int("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk_int("drain_timeout", sb.size(), 0);
  endtask

  logic [31:0] vec2 [5] = '{32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h40000000, 32'hC0000000};
  logic [31:0] spec [5] = '{32'h7FC00001, 32'h42B20000, 32'hC2B00000, 32'hFF800000, 32'h00000001};

  initial begin
    logic [31:0] xb;
    int          n, seen;
    real         taylor, term;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_bits("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk_bits("reset_result", result, 32'd0);
    chk_bits("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    send(32'h00000000, 4);
    send(32'h80000000, 4);
    drain();
    foreach (vec2[i]) send(vec2[i], 4);
    drain();
    foreach (spec[i]) send(spec[i], 4);
    drain();

    for (int i = 0; i < 30; i++) begin
      xb = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 128)), 23'($urandom)};
      send(xb, 8);
    end
    drain();

    // Back-pressure: result and handshakes frozen while the consumer stalls.
    out_ready = 1'b0;
    send(32'h3F800000, 4);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_bits("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk_bits("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk_close("hold_result", result, $exp(1.0), 4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_bits("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk_bits("release_out_valid", {31'd0, out_valid}, 32'd0);
    send(32'h40000000, 4);
    send(32'hBF000000, 4);
    send(32'h3E800000, 4);
    drain();

    // Reset during POLY abandons the operation.
    send(32'h3F800000, 4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_bits("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk_bits("midreset_result", result, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk_int("stale_output_cycles", seen, 0);
    send(32'h3F800000, 4);
    drain();

    // Legacy configuration: truncated 5-term Taylor series without range reduction.
    taylor = 0.0;
    term = 1.0;
    for (int i = 0; i <= 5; i++) begin
      taylor += term;
      term = term * 2.0 / real'(i + 1);
    end
    l_x = 32'h40000000;
    l_in_valid = 1'b1;
    for (int t = 0; t < 20 && !l_in_ready; t++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    l_in_valid = 1'b0;
    n = 1;
    while (!l_out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_int("legacy_latency", n, 9);
    chk_close("legacy_value", l_result, taylor, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
